local_injection_unit: RTL and testbench
=======================================

// Module: local_injection_unit
// PURPOSE
//  Network interface on the LOCAL input port of a quadtree router. Accepts
//  packets from the local PE over a valid/ready handshake and buffers them in
//  a FIFO. Formats each packet as a single flit. Injects flits into the
//  router's LOCAL input port under credit-based flow control, tracking the
//  free slots in the router's LOCAL input buffer.
// PARAMETERS
//  DATA_WIDTH   32  payload bits per flit
//  ADDR_WIDTH   8   routing address bits
//  INFO_WIDTH   2   routing info bits
//  FIFO_DEPTH   4   injection FIFO entries (power of 2, >=2)
//  CREDIT_INIT  2   router LOCAL input buffer depth = credits after reset (>=1)
// PORTS
//  clk            in   1   system clock
//  rst            in   1   asynchronous reset, active low
//  pe_valid       in   1   PE packet valid
//  pe_ready       out  1   FIFO can accept (count < FIFO_DEPTH)
//  pe_info        in   INFO_WIDTH  routing info
//  pe_addr        in   ADDR_WIDTH  routing address
//  pe_data        in   DATA_WIDTH  payload
//  out_data_valid out  1   flit valid to router LOCAL in_data_valid
//  out_data       out  FLIT_W  flit {info,addr,data}, FLIT_W=INFO+ADDR+DATA
//  credit_in      in   1   one-cycle credit return from router LOCAL in_credit
//  credit_count   out  clog2(CREDIT_INIT+1)  current credits
//  credit_err     out  1   sticky: credit return while count==CREDIT_INIT
//  idle           out  1   FIFO empty and credit_count==CREDIT_INIT
// BEHAVIOUR
//  - Reset (rst=0, async): FIFO empty, pointers 0, out_data_valid=0,
//    out_data=0, credit_count=CREDIT_INIT, credit_err=0, pe_ready=1, idle=1.
//  - Push: at a rising edge with pe_valid & pe_ready, write {pe_info,pe_addr,
//    pe_data} at wr_ptr; wr_ptr wraps modulo FIFO_DEPTH. pe_ready is
//    combinational from the registered count only; no dependence on pe_valid.
//  - Send: at a rising edge with count>0 (pre-edge) and credit_count>0
//    (pre-edge), pop head into out_data and set out_data_valid=1 for exactly
//    that cycle. Otherwise out_data_valid=0 and out_data holds its value.
//  - One flit per cycle maximum. Back-to-back sends are allowed while credits
//    last.
//  - Latency: packet accepted at edge t appears on out_data at edge t+1,
//    given free credit and an empty FIFO. There is no same-edge bypass.
//  - Push and pop at the same edge: both happen and count is unchanged. When
//    full, pop frees a slot, but pe_ready was already 0, so no push occurs.
//  - Credits: send decrements the count by 1; credit_in increments it by 1.
//    Both at the same edge leave it unchanged. Credits never drop below 0,
//    because send is gated.
//  - Credit overflow: credit_in with no send while credit_count==CREDIT_INIT
//    leaves the count saturated at CREDIT_INIT and sets credit_err=1.
//    credit_err clears only on reset.
//  - Ordering is strict FIFO. Flit bit order is [FLIT_W-1 -: INFO_WIDTH]=info,
//    then addr, then data[DATA_WIDTH-1:0].
//  - Reset mid-operation: buffered and in-flight packets are discarded. The
//    credit count returns to CREDIT_INIT. The router is reset in the same
//    domain.
// TESTING
//  1 Reset: hold rst=0 for 3 cycles, then release -> pe_ready=1, idle=1,
//    credit_count=2, out_data_valid=0.
//  2 Single packet: push info=1, addr=8'h5A, data=32'hDEADBEEF at edge t ->
//    out_data_valid=1 only after edge t+1 with that flit; credit_count=1;
//    after credit_in, count=2 and idle=1.
//  3 Credit stall: push 4 packets back-to-back with no credit_in -> exactly 2
//    flits sent. FIFO holds 2 and pe_ready stays 1. Pulse credit_in once ->
//    the 3rd flit is sent the next edge, in order.
//  4 Full FIFO: credit_in=0 and credits exhausted, push 4 more -> count=4 and
//    pe_ready=0. A 5th pe_valid is not accepted and no data is corrupted.
//  5 Simultaneous: at credit_count=0 with a queued flit, assert credit_in and
//    push on the same edge -> at the next edge one send occurs, and credit
//    returns to 0 only if no further credit_in arrives.
//  6 Overflow: at idle, pulse credit_in -> credit_err=1 and credit_count stays
//    2. Assert rst=0 mid-stream -> all outputs return to reset values
//    asynchronously.

Source files
------------

// File: rtl/local_injection_unit.sv
// Local-port network interface for a quadtree router: buffers PE packets in a small FIFO and
// injects them as single flits under credit-based flow control.
module local_injection_unit #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH  = 8,
  parameter int unsigned INFO_WIDTH  = 2,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned CREDIT_INIT = 2,
  localparam int unsigned FLIT_W     = INFO_WIDTH + ADDR_WIDTH + DATA_WIDTH,
  localparam int unsigned CREDIT_W   = $clog2(CREDIT_INIT + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pe_valid,
  output logic                  pe_ready,
  input  logic [INFO_WIDTH-1:0] pe_info,
  input  logic [ADDR_WIDTH-1:0] pe_addr,
  input  logic [DATA_WIDTH-1:0] pe_data,
  output logic                  out_data_valid,
  output logic [FLIT_W-1:0]     out_data,
  input  logic                  credit_in,
  output logic [CREDIT_W-1:0]   credit_count,
  output logic                  credit_err,
  output logic                  idle
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);

  logic [FLIT_W-1:0]   mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]     count_q, count_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic                err_q, err_d;
  logic                valid_q, valid_d;
  logic [FLIT_W-1:0]   flit_q, flit_d;
  logic                push, pop;

  // Ready depends only on registered occupancy so the PE never sees a comb path from its valid.
  assign pe_ready = (count_q < CntW'(FIFO_DEPTH));
  assign push     = pe_valid & pe_ready;
  assign pop      = (count_q != '0) & (credit_q != '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    valid_d = pop;
    flit_d  = flit_q;
    if (pop) flit_d = mem_q[rd_ptr_q];
  end

  // A send and a returning credit cancel; a surplus credit at full count saturates and flags.
  always_comb begin
    credit_d = credit_q;
    err_d    = err_q;
    case ({credit_in, pop})
      2'b10: begin
        if (credit_q == CREDIT_W'(CREDIT_INIT)) err_d = 1'b1;
        else                                    credit_d = credit_q + CREDIT_W'(1);
      end
      2'b01:   credit_d = credit_q - CREDIT_W'(1);
      default: credit_d = credit_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      credit_q <= CREDIT_W'(CREDIT_INIT);
      err_q    <= 1'b0;
      valid_q  <= 1'b0;
      flit_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      credit_q <= credit_d;
      err_q    <= err_d;
      valid_q  <= valid_d;
      flit_q   <= flit_d;
    end
  end

  // Storage needs no reset: occupancy and pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {pe_info, pe_addr, pe_data};
  end

  assign out_data_valid = valid_q;
  assign out_data       = flit_q;
  assign credit_count   = credit_q;
  assign credit_err     = err_q;
  assign idle           = (count_q == '0) && (credit_q == CREDIT_W'(CREDIT_INIT));

endmodule

// File: tb/tb_local_injection_unit.sv
// Randomized plus directed bench for local_injection_unit with a queue-based reference model
// and a scoreboard monitor that checks every emitted flit in order.
module tb_local_injection_unit;
  localparam int DW = 32;
  localparam int AW = 8;
  localparam int IW = 2;
  localparam int DEPTH = 4;
  localparam int CINIT = 2;
  localparam int FW = IW + AW + DW;
  localparam int CW = $clog2(CINIT + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          pe_valid = 1'b0;
  logic          pe_ready;
  logic [IW-1:0] pe_info = '0;
  logic [AW-1:0] pe_addr = '0;
  logic [DW-1:0] pe_data = '0;
  logic          out_data_valid;
  logic [FW-1:0] out_data;
  logic          credit_in = 1'b0;
  logic [CW-1:0] credit_count;
  logic          credit_err;
  logic          idle;
  logic [FW-1:0] flit_in;

  assign flit_in = {pe_info, pe_addr, pe_data};

  always #5 clk = ~clk;

  local_injection_unit #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .INFO_WIDTH (IW),
    .FIFO_DEPTH (DEPTH),
    .CREDIT_INIT(CINIT)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .pe_valid      (pe_valid),
    .pe_ready      (pe_ready),
    .pe_info       (pe_info),
    .pe_addr       (pe_addr),
    .pe_data       (pe_data),
    .out_data_valid(out_data_valid),
    .out_data      (out_data),
    .credit_in     (credit_in),
    .credit_count  (credit_count),
    .credit_err    (credit_err),
    .idle          (idle)
  );

  int n_cmp = 0;
  int n_fail = 0;

  // Reference model: packet queue, integer credit counter, sticky error, last-sent flit.
  logic [FW-1:0] sb_q[$];
  logic [FW-1:0] mq[$];
  int            m_credit = CINIT;
  bit            m_err = 1'b0;
  bit            m_valid = 1'b0;
  logic [FW-1:0] m_last = '0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  initial begin
    bit send, acc;
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        mq.delete();
        sb_q.delete();
        m_credit = CINIT;
        m_err    = 1'b0;
        m_valid  = 1'b0;
        m_last   = '0;
      end else begin
        send    = (mq.size() > 0) && (m_credit > 0);
        acc     = pe_valid && (mq.size() < DEPTH);
        m_valid = send;
        if (send) m_last = mq.pop_front();
        if (acc) begin
          mq.push_back(flit_in);
          sb_q.push_back(flit_in);
        end
        if (send && !credit_in) m_credit--;
        else if (credit_in && !send) begin
          if (m_credit == CINIT) m_err = 1'b1;
          else m_credit++;
        end
      end
    end
  end

  // Monitor: sampled on the falling edge, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      chk("out_valid", 64'(out_data_valid), 64'(m_valid));
      chk("out_data_hold", 64'(out_data), 64'(m_last));
      chk("credit_count", 64'(credit_count), 64'(m_credit));
      chk("credit_err", 64'(credit_err), 64'(m_err));
      chk("pe_ready", 64'(pe_ready), 64'(mq.size() < DEPTH));
      chk("idle", 64'(idle), 64'(mq.size() == 0 && m_credit == CINIT));
      if (out_data_valid) begin
        if (sb_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL sb_underflow: got flit %0h expected no flit at %0t", out_data, $time);
        end else begin
          chk("sb_flit", 64'(out_data), 64'(sb_q.pop_front()));
        end
      end
    end
  end

  task automatic drive(input bit v, input bit c);
    pe_valid  = v;
    credit_in = c;
    pe_info   = IW'($urandom);
    pe_addr   = AW'($urandom);
    pe_data   = $urandom;
    @(negedge clk);
  endtask

  task automatic drain();
    for (int i = 0; i < 40; i++) begin
      if (mq.size() == 0 && m_credit == CINIT) break;
      drive(1'b0, m_credit < CINIT);
    end
    drive(1'b0, 1'b0);
    chk("drained_idle", 64'(idle), 64'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_valid"}, 64'(out_data_valid), 64'd0);
    chk({tag, "_data"}, 64'(out_data), 64'd0);
    chk({tag, "_credit"}, 64'(credit_count), 64'(CINIT));
    chk({tag, "_err"}, 64'(credit_err), 64'd0);
    chk({tag, "_ready"}, 64'(pe_ready), 64'd1);
    chk({tag, "_idle"}, 64'(idle), 64'd1);
  endtask

  initial begin
    logic [FW-1:0] exp_flit;
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    check_reset_outputs("reset");

    // Single packet: no same-edge bypass, one cycle of latency.
    pe_valid = 1'b1;
    pe_info  = 2'd1;
    pe_addr  = 8'h5A;
    pe_data  = 32'hDEADBEEF;
    exp_flit = {2'd1, 8'h5A, 32'hDEADBEEF};
    @(negedge clk);
    chk("single_no_bypass", 64'(out_data_valid), 64'd0);
    pe_valid = 1'b0;
    @(negedge clk);
    chk("single_valid", 64'(out_data_valid), 64'd1);
    chk("single_flit", 64'(out_data), 64'(exp_flit));
    chk("single_credit", 64'(credit_count), 64'd1);
    drive(1'b0, 1'b1);
    drive(1'b0, 1'b0);
    chk("single_idle", 64'(idle), 64'd1);
    chk("single_credit_back", 64'(credit_count), 64'd2);

    // Credit stall: only two flits leave without returned credits.
    repeat (4) drive(1'b1, 1'b0);
    repeat (2) drive(1'b0, 1'b0);
    chk("stall_credit", 64'(credit_count), 64'd0);
    chk("stall_ready", 64'(pe_ready), 64'd1);
    drive(1'b0, 1'b1);
    drive(1'b0, 1'b0);
    chk("stall_third_sent", 64'(out_data_valid), 64'd1);

    // Fill the FIFO while starved; extra pushes must be refused.
    repeat (5) drive(1'b1, 1'b0);
    chk("full_ready", 64'(pe_ready), 64'd0);
    drive(1'b0, 1'b0);

    // Simultaneous credit return and push with a queued flit.
    drive(1'b0, 1'b1);
    repeat (2) drive(1'b0, 1'b0);
    drive(1'b1, 1'b1);
    repeat (2) drive(1'b0, 1'b0);
    drain();

    // Overflow at idle.
    drive(1'b0, 1'b1);
    drive(1'b0, 1'b0);
    chk("ovf_err", 64'(credit_err), 64'd1);
    chk("ovf_credit", 64'(credit_count), 64'd2);

    // Random traffic with a mid-stream asynchronous reset.
    for (int i = 0; i < 400; i++) begin
      if (i == 200) begin
        #3 rst = 1'b0;
        #1 check_reset_outputs("async_rst");
        @(negedge clk);
        rst = 1'b1;
      end
      drive($urandom_range(0, 2) != 0,
            ((m_credit < CINIT) && ($urandom_range(0, 2) != 0)) || ($urandom_range(0, 60) == 0));
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
